dmem_arbiter: RTL

//  Shares the single data-memory port between the pipeline's M stage (requester 0, CPU) and a

---
 rtl/dmem_arbiter_pkg.sv | 22 ++
 rtl/dmem_arbiter_sat_counter.sv | 27 ++
 rtl/dmem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DEF_XLEN      = 32;
    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_MAX_WAIT  = 4;
    localparam int unsigned DEF_BURST_MAX = 8;
    localparam int unsigned AMP_W         = 4;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        S_CPU   = 2'd0,
        S_LOCK  = 2'd1,
        S_YIELD = 2'd2
    } arbState_t;

    // Bits needed to hold a counter value 0..maxVal
    function automatic int unsigned cntWidth(input int unsigned maxVal);
        return 32'($clog2(maxVal + 1));
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W   = 3,
    parameter int unsigned MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         at_max
);

    assign at_max = (q == W'(MAX));

    // Count register: clear, else increment until MAX, else hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !at_max) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the M stage (CPU) and a debug/loader
// master. CPU has default priority; DBG gets bounded waiting and locked bursts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned XLEN      = DEF_XLEN,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT,
    parameter int unsigned BURST_MAX = DEF_BURST_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [XLEN-1:0]   cpu_wdata,
    input  logic [AMP_W-1:0]  cpu_amp,
    output logic [XLEN-1:0]   cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]   dbg_wdata,
    input  logic [AMP_W-1:0]  dbg_amp,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [XLEN-1:0]   dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_we,
    output logic [AMP_W-1:0]  mem_amp,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned WAIT_W  = cntWidth(MAX_WAIT);
    localparam int unsigned BURST_W = cntWidth(BURST_MAX);

    arbState_t          state;
    arbState_t          stateNext;

    logic [WAIT_W-1:0]  waitCnt;
    logic               waitAtMax;
    logic               waitInc;
    logic               waitClr;
    logic               waitForce;

    logic [BURST_W-1:0] burstCnt;
    logic               burstAtMax;
    logic               burstInc;
    logic               burstClr;
    logic               burstLast;

    logic               dbgWin;
    logic               cpuWin;

    // How long DBG has been kept waiting
    sat_counter #(
        .W   (WAIT_W),
        .MAX (MAX_WAIT)
    ) uWaitCnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (waitInc),
        .clr    (waitClr),
        .q      (waitCnt),
        .at_max (waitAtMax)
    );

    // Grants taken in the current locked burst
    sat_counter #(
        .W   (BURST_W),
        .MAX (BURST_MAX)
    ) uBurstCnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (burstInc),
        .clr    (burstClr),
        .q      (burstCnt),
        .at_max (burstAtMax)
    );

    assign waitForce = (waitCnt == WAIT_W'(MAX_WAIT));
    assign burstLast = (burstCnt == BURST_W'(BURST_MAX - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_CPU;
        end else begin
            state <= stateNext;
        end
    end

    // Grant selection, counter control, next state and port mux
    always_comb begin
        stateNext = state;
        dbgWin    = 1'b0;
        cpuWin    = 1'b0;
        waitInc   = 1'b0;
        waitClr   = 1'b0;
        burstInc  = 1'b0;
        burstClr  = 1'b0;
        dbg_gnt   = 1'b0;
        cpu_stall = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_amp   = cpu_amp;
        mem_we    = 1'b0;

        case (state)
            S_CPU:   dbgWin = dbg_req & (~cpu_req | waitForce);
            S_LOCK:  dbgWin = dbg_req & ~burstAtMax;
            S_YIELD: dbgWin = dbg_req & ~cpu_req;
            default: dbgWin = 1'b0;
        endcase

        // Nothing is granted while reset is held
        if (reset) begin
            dbgWin = 1'b0;
        end
        cpuWin = cpu_req & ~dbgWin & ~reset;

        // DBG waiting time restarts whenever it is served or withdraws
        waitInc = dbg_req & ~dbgWin & ~waitAtMax;
        waitClr = dbgWin | ~dbg_req;

        case (state)
            S_CPU: begin
                if (dbgWin && dbg_lock) begin
                    burstInc  = 1'b1;
                    stateNext = burstLast ? S_YIELD : S_LOCK;
                end
            end
            S_LOCK: begin
                if (!dbg_req || !dbg_lock) begin
                    burstClr  = 1'b1;
                    stateNext = S_CPU;
                end else if (burstAtMax) begin
                    stateNext = S_YIELD;
                end else begin
                    burstInc = dbgWin;
                    if (dbgWin && burstLast) begin
                        stateNext = S_YIELD;
                    end
                end
            end
            S_YIELD: begin
                burstClr  = 1'b1;
                stateNext = S_CPU;
            end
            default: begin
                burstClr  = 1'b1;
                stateNext = S_CPU;
            end
        endcase

        dbg_gnt   = dbgWin;
        cpu_stall = cpu_req & (dbgWin | reset);

        if (dbgWin) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_amp   = dbg_amp;
            mem_we    = dbg_we;
        end else begin
            mem_we    = cpuWin & cpu_we;
        end
    end

    assign cpu_rdata = mem_rdata;

    // DBG read return: one-cycle valid pulse with the data captured at grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            dbg_rvalid <= dbgWin & ~dbg_we;
            if (dbgWin && !dbg_we) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule
